// File: rtl/t02_mem_arb_pkg.sv
// Shared types for the fetch/data RAM bus arbiter.
package t02_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/t02_mem_arbiter.sv
// Shares the single-port RAM bus between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants taken while fetch was waiting.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate pending requests, latch the winner
// ACCESS | strobe the RAM with the latched request until busy drops
// RESP   | one-cycle ready pulse to the owner, no new grant
module t02_mem_arbiter
    import t02_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
)(
    input  logic              clk,
    input  logic              nRST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    state_t             state;
    owner_t             owner_q;
    op_t                op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CNT_W-1:0]   starve_cnt;

    logic d_req;
    logic fetch_forced;
    logic grant_d;
    logic grant_i;

    // Arbitration decision; only acted on while IDLE.
    always_comb begin
        d_req        = d_ren | d_wen;
        fetch_forced = i_req && (starve_cnt == CNT_W'(STARVE_MAX));
        grant_d      = d_req && !fetch_forced;
        grant_i      = i_req && !grant_d;
    end

    // The address/data latches double as the RAM bus output registers;
    // they are cleared when the access ends so the bus is quiet outside ACCESS.
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    // Sequencer: grant, hold the access until RAM is free, pulse ready.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            owner_q <= OWN_I;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= ACCESS;
                        owner_q <= OWN_D;
                        // A simultaneous read+write request is served as a read.
                        op_q    <= d_ren ? OP_RD : OP_WR;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        ram_ren <= d_ren;
                        ram_wen <= !d_ren;
                    end else if (grant_i) begin
                        state   <= ACCESS;
                        owner_q <= OWN_I;
                        op_q    <= OP_RD;
                        addr_q  <= i_addr;
                        wdata_q <= '0;
                        ram_ren <= 1'b1;
                        ram_wen <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!ram_busy) begin
                        state   <= RESP;
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        if (op_q == OP_RD) begin
                            if (owner_q == OWN_I) begin
                                i_rdata <= ram_rdata;
                            end else begin
                                d_rdata <= ram_rdata;
                            end
                        end
                        i_ready <= (owner_q == OWN_I);
                        d_ready <= (owner_q == OWN_D);
                    end
                end
                RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Consecutive data grants taken while fetch was waiting.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                if (!i_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else if (grant_i) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Bench for the fetch/data RAM arbiter: directed scenarios plus a randomized
// run checked against a transaction-timeline model of the arbiter.
module tb_t02_mem_arbiter;

    localparam int SM = 4;

    logic        clk;
    logic        nRST;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_busy;

    int n_tests;
    int n_fail;

    t02_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_busy  (ram_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req     = 1'b0;
        i_addr    = '0;
        d_ren     = 1'b0;
        d_wen     = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        ram_rdata = '0;
        ram_busy  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        step();
        step();
        n_tests++;
        if ({ram_ren, ram_wen, i_ready, d_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000", {ram_ren, ram_wen, i_ready, d_ready});
        end
        n_tests++;
        if ({ram_addr, ram_wdata, i_rdata, d_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h want all zero", ram_addr, ram_wdata, i_rdata, d_rdata);
        end
        nRST = 1'b1;
        step();
        step();
        n_tests++;
        if ({ram_ren, ram_wen, i_ready, d_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_quiet: got %b want 0000", {ram_ren, ram_wen, i_ready, d_ready});
        end
    endtask

    task automatic test_fetch_only();
        i_req = 1'b1; i_addr = 32'h100; ram_busy = 1'b0; ram_rdata = 32'hDEADBEEF;
        step();
        n_tests++;
        if (ram_ren !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== 32'h100 || i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_issue: got ren=%b wen=%b addr=%h rdy=%b want 1 0 100 0", ram_ren, ram_wen, ram_addr, i_ready);
        end
        step();
        n_tests++;
        if (i_ready !== 1'b1 || i_rdata !== 32'hDEADBEEF || ram_ren !== 1'b0 || d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp: got rdy=%b rdata=%h ren=%b drdy=%b want 1 deadbeef 0 0", i_ready, i_rdata, ram_ren, d_ready);
        end
        i_addr = 32'h104; ram_rdata = 32'h11112222;
        step();
        n_tests++;
        if (ram_ren !== 1'b0 || i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_no_reissue: got ren=%b rdy=%b want 0 0", ram_ren, i_ready);
        end
        step();
        n_tests++;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL fetch_second_issue: got ren=%b addr=%h want 1 104", ram_ren, ram_addr);
        end
        step();
        n_tests++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h11112222) begin
            n_fail++;
            $display("FAIL fetch_second_resp: got rdy=%b rdata=%h want 1 11112222", i_ready, i_rdata);
        end
        i_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_simultaneous();
        i_req = 1'b1; i_addr = 32'h200;
        d_ren = 1'b1; d_addr = 32'h8000;
        ram_busy = 1'b0; ram_rdata = 32'hA5A50001;
        step();
        n_tests++;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h8000) begin
            n_fail++;
            $display("FAIL simul_data_first: got ren=%b addr=%h want 1 8000", ram_ren, ram_addr);
        end
        step();
        n_tests++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== 32'hA5A50001) begin
            n_fail++;
            $display("FAIL simul_data_resp: got drdy=%b irdy=%b rdata=%h want 1 0 a5a50001", d_ready, i_ready, d_rdata);
        end
        d_ren = 1'b0; ram_rdata = 32'h0BADF00D;
        step();
        n_tests++;
        if (ram_ren !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_idle_gap: got ren=%b want 0", ram_ren);
        end
        step();
        n_tests++;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL simul_fetch_issue: got ren=%b addr=%h want 1 200", ram_ren, ram_addr);
        end
        step();
        n_tests++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL simul_fetch_resp: got irdy=%b drdy=%b rdata=%h want 1 0 0badf00d", i_ready, d_ready, i_rdata);
        end
        i_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_starvation();
        bit exp_seq[10];
        bit got_seq[$];
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        i_req = 1'b1; i_addr = 32'h300;
        d_ren = 1'b1; d_addr = 32'h1000;
        ram_busy = 1'b0; ram_rdata = 32'h5555AAAA;
        for (int cyc = 0; cyc < 80 && got_seq.size() < 10; cyc++) begin
            step();
            if (d_ready) begin
                got_seq.push_back(1'b1);
                d_addr = d_addr + 32'h4;
            end
            if (i_ready) begin
                got_seq.push_back(1'b0);
                i_addr = i_addr + 32'h4;
            end
        end
        n_tests++;
        if (got_seq.size() != 10) begin
            n_fail++;
            $display("FAIL starve_count: got %0d completions want 10", got_seq.size());
        end
        for (int k = 0; k < 10 && k < got_seq.size(); k++) begin
            n_tests++;
            if (got_seq[k] !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL starve_order[%0d]: got owner %s want %s", k,
                         got_seq[k] ? "data" : "fetch", exp_seq[k] ? "data" : "fetch");
            end
        end
        i_req = 1'b0; d_ren = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_write_stall();
        d_wen = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        ram_busy = 1'b1; ram_rdata = 32'hFFFF0000;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_tests++;
            if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_addr !== 32'h40 ||
                ram_wdata !== 32'h12345678 || d_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_stall_cycle%0d: got wen=%b ren=%b addr=%h wdata=%h rdy=%b want 1 0 40 12345678 0",
                         k, ram_wen, ram_ren, ram_addr, ram_wdata, d_ready);
            end
            if (k == 2) begin
                d_addr = 32'h99; d_wdata = 32'h0;
            end
            ram_busy = (k < 6);
        end
        step();
        n_tests++;
        if (d_ready !== 1'b1 || ram_wen !== 1'b0 || d_rdata !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL wr_stall_resp: got rdy=%b wen=%b rdata=%h want 1 0 5555aaaa", d_ready, ram_wen, d_rdata);
        end
        d_wen = 1'b0;
        step();
        step();
    endtask

    task automatic test_both_rw();
        d_ren = 1'b1; d_wen = 1'b1; d_addr = 32'h44; d_wdata = 32'h1;
        ram_busy = 1'b0; ram_rdata = 32'hCAFE0000;
        step();
        n_tests++;
        if (ram_ren !== 1'b1 || ram_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL both_rw_strobe: got ren=%b wen=%b want 1 0", ram_ren, ram_wen);
        end
        step();
        n_tests++;
        if (d_ready !== 1'b1 || d_rdata !== 32'hCAFE0000) begin
            n_fail++;
            $display("FAIL both_rw_resp: got rdy=%b rdata=%h want 1 cafe0000", d_ready, d_rdata);
        end
        d_ren = 1'b0; d_wen = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        int  ndata;
        bit  fetch_seen;
        i_req = 1'b1; i_addr = 32'h500;
        d_ren = 1'b1; d_addr = 32'h600;
        ram_busy = 1'b1;
        step();
        n_tests++;
        if (ram_ren !== 1'b1 || ram_addr !== 32'h600) begin
            n_fail++;
            $display("FAIL rstmid_issue: got ren=%b addr=%h want 1 600", ram_ren, ram_addr);
        end
        step();
        #2;
        nRST = 1'b0;
        #1;
        n_tests++;
        if ({ram_ren, ram_wen, i_ready, d_ready, ram_addr, ram_wdata, i_rdata, d_rdata} !== 132'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got ren=%b wen=%b irdy=%b drdy=%b addr=%h wdata=%h ir=%h dr=%h want all zero",
                     ram_ren, ram_wen, i_ready, d_ready, ram_addr, ram_wdata, i_rdata, d_rdata);
        end
        i_req = 1'b0; d_ren = 1'b0; ram_busy = 1'b0;
        step();
        step();
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++;
            if ({ram_ren, ram_wen, i_ready, d_ready} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rstmid_quiet%0d: got %b want 0000", k, {ram_ren, ram_wen, i_ready, d_ready});
            end
        end
        i_req = 1'b1; d_ren = 1'b1; ram_rdata = 32'h77;
        ndata = 0;
        fetch_seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !fetch_seen; cyc++) begin
            step();
            if (d_ready) ndata++;
            if (i_ready) fetch_seen = 1'b1;
        end
        n_tests++;
        if (!fetch_seen || ndata != SM) begin
            n_fail++;
            $display("FAIL rstmid_starve_clear: got %0d data grants before fetch (fetch seen=%b) want %0d", ndata, fetch_seen, SM);
        end
        i_req = 1'b0; d_ren = 1'b0;
        step();
        step();
        step();
    endtask

    // Randomized traffic. The model describes each transaction as a timeline:
    // granted in cycle g, RAM strobed in cycles g+1..g+1+stall, ready in
    // cycle g+2+stall, next grant possible from cycle g+3+stall.
    task automatic test_random();
        int          c, g, stall, free_at, starve, done, i_gap, d_gap, kind;
        bit          act, own_d, wr, in_acc, in_resp;
        logic [31:0] t_addr, t_wdata, cap, exp_i, exp_d;
        idle_inputs();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
        act = 1'b0; own_d = 1'b0; wr = 1'b0;
        g = 0; stall = 0; free_at = 0; starve = 0; done = 0;
        i_gap = 0; d_gap = 1; c = 0;
        t_addr = '0; t_wdata = '0; cap = '0; exp_i = '0; exp_d = '0;
        while (done < 200 && c < 4000) begin
            step();
            c++;
            in_acc  = act && (c >= g + 1) && (c <= g + 1 + stall);
            in_resp = act && (c == g + 2 + stall);
            if (in_resp && !wr) begin
                if (own_d) exp_d = cap;
                else       exp_i = cap;
            end
            n_tests++;
            if (ram_ren !== (in_acc && !wr) || ram_wen !== (in_acc && wr)) begin
                n_fail++;
                $display("FAIL rnd_strobe c=%0d: got ren=%b wen=%b want %b %b", c, ram_ren, ram_wen, in_acc && !wr, in_acc && wr);
            end
            if (in_acc) begin
                n_tests++;
                if (ram_addr !== t_addr || (wr && ram_wdata !== t_wdata)) begin
                    n_fail++;
                    $display("FAIL rnd_bus c=%0d: got addr=%h wdata=%h want %h %h", c, ram_addr, ram_wdata, t_addr, t_wdata);
                end
            end
            n_tests++;
            if (i_ready !== (in_resp && !own_d) || d_ready !== (in_resp && own_d)) begin
                n_fail++;
                $display("FAIL rnd_ready c=%0d: got irdy=%b drdy=%b want %b %b", c, i_ready, d_ready, in_resp && !own_d, in_resp && own_d);
            end
            n_tests++;
            if (i_rdata !== exp_i || d_rdata !== exp_d) begin
                n_fail++;
                $display("FAIL rnd_rdata c=%0d: got i=%h d=%h want %h %h", c, i_rdata, d_rdata, exp_i, exp_d);
            end
            if (in_resp) begin
                done++;
                if (own_d) begin
                    d_ren = 1'b0; d_wen = 1'b0; d_gap = $urandom_range(0, 2);
                end else begin
                    i_req = 1'b0; i_gap = $urandom_range(0, 3);
                end
            end
            // The owner's inputs may wander during its access; the latches must hold.
            if (in_acc && $urandom_range(0, 1) == 1) begin
                if (own_d) begin
                    d_addr = $urandom; d_wdata = $urandom;
                end else begin
                    i_addr = $urandom;
                end
            end
            if (!i_req) begin
                if (i_gap == 0) begin
                    i_req = 1'b1; i_addr = $urandom;
                end else begin
                    i_gap--;
                end
            end
            if (!(d_ren || d_wen)) begin
                if (d_gap == 0) begin
                    kind = $urandom_range(0, 3);
                    d_ren = (kind != 2); d_wen = (kind >= 2);
                    d_addr = $urandom; d_wdata = $urandom;
                end else begin
                    d_gap--;
                end
            end
            ram_rdata = $urandom;
            if (in_acc) begin
                ram_busy = (c < g + 1 + stall);
                if (c == g + 1 + stall) cap = ram_rdata;
            end else begin
                ram_busy = ($urandom_range(0, 1) == 1);
            end
            if (act && c >= free_at) act = 1'b0;
            if (!act) begin
                if ((d_ren || d_wen) && !(i_req && starve == SM)) begin
                    act = 1'b1; own_d = 1'b1; wr = d_wen && !d_ren;
                    t_addr = d_addr; t_wdata = d_wdata;
                    starve = i_req ? ((starve < SM) ? starve + 1 : SM) : 0;
                end else if (i_req) begin
                    act = 1'b1; own_d = 1'b0; wr = 1'b0;
                    t_addr = i_addr; t_wdata = '0;
                    starve = 0;
                end
                if (act) begin
                    g = c;
                    stall = $urandom_range(0, 3);
                    free_at = g + stall + 3;
                end
            end
        end
        n_tests++;
        if (done < 200) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d completions want 200 within cycle budget", done);
        end
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nRST    = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_write_stall();
        test_both_rw();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
